// File: rtl/rtc_pkg.sv
// Shared definitions for the multiplexed-bus RTC sequencers (read and write side).
// Contents:
//   - RTC register addresses (write-side control registers, time/date registers)
//   - read-sequencer state encoding
//   - number of registers per snapshot and default handshake timing
//   - reg_addr(): snapshot index -> RTC register address
package rtc_pkg;

  // Registers already used by the power-up write sequencer.
  localparam logic [7:0] ADDR_CTRL = 8'h02;
  localparam logic [7:0] ADDR_STAT = 8'h10;
  localparam logic [7:0] ADDR_CMD  = 8'hF0;

  // Time/date registers, in snapshot order.
  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HOR  = 8'h23;
  localparam logic [7:0] ADDR_DIA  = 8'h24;
  localparam logic [7:0] ADDR_MES  = 8'h25;
  localparam logic [7:0] ADDR_ANIO = 8'h26;

  localparam int N_REGS      = 6;
  localparam int HOLD_DEF    = 2;
  localparam int TIMEOUT_DEF = 255;

  // Read-sequencer states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic [7:0] reg_addr(input logic [2:0] idx);
    logic [7:0] addr;
    case (idx)
      3'd0:    addr = ADDR_SEG;
      3'd1:    addr = ADDR_MIN;
      3'd2:    addr = ADDR_HOR;
      3'd3:    addr = ADDR_DIA;
      3'd4:    addr = ADDR_MES;
      3'd5:    addr = ADDR_ANIO;
      default: addr = 8'h00;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/rtc_handshake.sv
// Bus-driver handshake timer shared by the RTC read and write sequencers.
// The sequencer raises `issuing` while the address/strobe are held and
// `waiting` while it waits for the driver; this block reports when the hold
// time is over, when the transfer completed, and when it timed out.
// Ports:
//   clk, reset   system clock, synchronous active-low reset
//   issuing      sequencer is holding address + strobe
//   waiting      sequencer is waiting for the driver to finish
//   siga         driver busy (1 = transfer in progress)
//   hold_done    last hold cycle (combinational, only while issuing)
//   done         transfer finished: busy was seen and is now low
//   timeout      last allowed wait cycle passed without completion
module rtc_handshake #(
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic issuing,
  input  logic waiting,
  input  logic siga,
  output logic hold_done,
  output logic done,
  output logic timeout
);

  logic [7:0] hold_cnt;
  logic [7:0] to_cnt;
  logic       visto_alto;

  assign hold_done = issuing && (hold_cnt == 8'(HOLD));
  // A low busy line only means "finished" once it has been seen high;
  // before that the driver simply has not picked the request up yet.
  assign done      = waiting && visto_alto && !siga;
  // Completion on the last allowed cycle wins over the timeout.
  assign timeout   = waiting && !done && (to_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the values from before this edge.
    if (!reset) begin
      hold_cnt   <= 8'd0;
      to_cnt     <= 8'd0;
      visto_alto <= 1'b0;
    end else begin
      hold_cnt <= (issuing && !hold_done) ? hold_cnt + 8'd1 : 8'd0;
      to_cnt   <= waiting ? to_cnt + 8'd1 : 8'd0;

      if (hold_done) begin
        // Start the wait phase with a clean flag; busy on this very cycle
        // still counts.
        visto_alto <= siga;
      end else if (issuing || waiting) begin
        if (siga) visto_alto <= 1'b1;
      end else begin
        visto_alto <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rtc_lectura.sv
// Read-side sequencer for the multiplexed-bus RTC.
// On an accepted read request it reads registers 0x21..0x26 one by one through
// the shared bus driver and publishes the six bytes together as one snapshot.
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   inicializado      init sequencer finished; reads refused while low
//   leer              read request (level or pulse), sampled in IDLE
//   siga              bus driver busy (1 = busy, 0 = idle/done)
//   dato_rd           byte returned by the bus driver
//   Direc, lea        register address and read strobe to the bus driver
//   ocupado           read in progress
//   segundos..anio    BCD snapshot of registers 0x21..0x26
//   valido            one-cycle pulse when a new snapshot is published
//   error_to          sticky timeout flag, cleared by the next accepted read
module rtc_lectura
  import rtc_pkg::*;
#(
  parameter int HOLD    = HOLD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicializado,
  input  logic       leer,
  input  logic       siga,
  input  logic [7:0] dato_rd,
  output logic [7:0] Direc,
  output logic       lea,
  output logic       ocupado,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       valido,
  output logic       error_to
);

  logic [2:0] state;
  logic [2:0] idx;
  logic [7:0] shadow [N_REGS];

  logic hold_done;
  logic done;
  logic timeout;

  rtc_handshake #(
    .HOLD    (HOLD),
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .clk       (clk),
    .reset     (reset),
    .issuing   (state == ST_ISSUE),
    .waiting   (state == ST_WAIT),
    .siga      (siga),
    .hold_done (hold_done),
    .done      (done),
    .timeout   (timeout)
  );

  // Bus-side outputs decode straight from the state so they are 0 in reset
  // and IDLE without extra registers.
  assign ocupado = (state != ST_IDLE);
  assign lea     = (state == ST_ISSUE);
  assign valido  = (state == ST_DONE);
  assign Direc   = (state == ST_ISSUE || state == ST_WAIT) ? reg_addr(idx) : 8'h00;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= 3'd0;
      error_to <= 1'b0;
      segundos <= 8'h00;
      minutos  <= 8'h00;
      horas    <= 8'h00;
      dia      <= 8'h00;
      mes      <= 8'h00;
      anio     <= 8'h00;
      // NOTE: the shadow bytes are a handful of flops, not a RAM, so they
      // can and do take the reset like everything else.
      for (int i = 0; i < N_REGS; i++) shadow[i] <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (leer && inicializado) begin
            idx      <= 3'd0;
            error_to <= 1'b0;
            state    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (hold_done) state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (done) begin
            shadow[idx] <= dato_rd;
            state       <= ST_NEXT;
          end else if (timeout) begin
            error_to <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        ST_NEXT: begin
          if (idx == 3'(N_REGS - 1)) begin
            // Load the snapshot on the edge into DONE so the new bytes and
            // the `valido` pulse appear on the same cycle, all at once.
            segundos <= shadow[0];
            minutos  <= shadow[1];
            horas    <= shadow[2];
            dia      <= shadow[3];
            mes      <= shadow[4];
            anio     <= shadow[5];
            state    <= ST_DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= ST_ISSUE;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_lectura.sv
module tb_rtc_lectura;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inicializado = 1'b0;
  logic       leer = 1'b0;
  logic       siga = 1'b0;
  logic [7:0] dato_rd = 8'h00;

  logic [7:0] Direc;
  logic       lea;
  logic       ocupado;
  logic [7:0] segundos, minutos, horas, dia, mes, anio;
  logic       valido;
  logic       error_to;

  int total = 0;
  int bad = 0;
  int valido_cnt = 0;

  rtc_lectura dut (
    .clk          (clk),
    .reset        (reset),
    .inicializado (inicializado),
    .leer         (leer),
    .siga         (siga),
    .dato_rd      (dato_rd),
    .Direc        (Direc),
    .lea          (lea),
    .ocupado      (ocupado),
    .segundos     (segundos),
    .minutos      (minutos),
    .horas        (horas),
    .dia          (dia),
    .mes          (mes),
    .anio         (anio),
    .valido       (valido),
    .error_to     (error_to)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valido === 1'b1) valido_cnt++;

  localparam logic [47:0] SNAP_A = 48'h45_30_12_07_04_17;
  localparam logic [47:0] SNAP_B = 48'h59_58_23_31_12_99;
  localparam logic [47:0] SNAP_C = 48'h00_01_02_28_02_24;
  localparam logic [47:0] ADDRS  = 48'h21_22_23_24_25_26;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_snap(input string tag, input logic [47:0] exp);
    check(tag, {segundos, minutos, horas, dia, mes, anio}, exp);
  endtask

  task automatic check_idle_zero(input string tag);
    check(tag, 48'({Direc, lea, ocupado, valido, error_to}), 48'h0);
  endtask

  // Wait (bounded) for the strobe for `addr`, then for the start of WAIT.
  task automatic wait_wait(input logic [7:0] addr);
    int n;
    n = 0;
    while (lea !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("lea_rise", 48'(lea), 48'h1);
    check("direc_issue", 48'(Direc), 48'(addr));
    n = 0;
    while (lea !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("issue_len", 48'(n), 48'd3);
    check("direc_wait", 48'(Direc), 48'(addr));
  endtask

  // Bus model: busy for 3 cycles, then idle with the data byte.
  task automatic serve(input logic [7:0] addr, input logic [7:0] data);
    wait_wait(addr);
    siga = 1'b1;
    dato_rd = 8'hxx;
    repeat (3) @(negedge clk);
    siga = 1'b0;
    dato_rd = data;
  endtask

  task automatic start_read();
    leer = 1'b1;
    @(negedge clk);
    leer = 1'b0;
  endtask

  task automatic run_read(input logic [47:0] data, input logic [47:0] old_snap, input string tag);
    logic [47:0] a;
    logic [47:0] d;
    a = ADDRS;
    d = data;
    for (int i = 0; i < 6; i++) begin
      serve(a[47-8*i -: 8], d[47-8*i -: 8]);
      check_snap({tag, "_atomic"}, old_snap);
    end
    @(negedge clk);  // NEXT of the last register
    check_snap({tag, "_pre_done"}, old_snap);
    check({tag, "_valido_pre"}, 48'(valido), 48'h0);
    @(negedge clk);  // DONE
    check({tag, "_valido"}, 48'(valido), 48'h1);
    check_snap({tag, "_snap"}, data);
  endtask

  initial begin
    int n;
    int vc;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_outs");
    check_snap("reset_snap", 48'h0);
    reset = 1'b1;
    @(negedge clk);

    // Read refused before init
    leer = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("blocked_ocupado", 48'(ocupado), 48'h0);
      check("blocked_lea", 48'(lea), 48'h0);
    end
    leer = 1'b0;
    inicializado = 1'b1;
    @(negedge clk);

    // Normal read
    start_read();
    check("busy_a", 48'(ocupado), 48'h1);
    run_read(SNAP_A, 48'h0, "read_a");
    @(negedge clk);
    check("valido_a_off", 48'(valido), 48'h0);
    check("idle_a", 48'(ocupado), 48'h0);
    check("valido_cnt_a", 48'(valido_cnt), 48'd1);

    // Request held for the whole read, init dropping mid-read
    leer = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) inicializado = 1'b0;
      serve(ADDRS[47-8*i -: 8], SNAP_B[47-8*i -: 8]);
      check_snap("read_b_atomic", SNAP_A);
    end
    @(negedge clk);
    check("read_b_valido_pre", 48'(valido), 48'h0);
    @(negedge clk);
    check("read_b_valido", 48'(valido), 48'h1);
    check_snap("read_b_snap", SNAP_B);
    leer = 1'b0;
    inicializado = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("read_b_no_requeue", 48'(ocupado), 48'h0);
    end
    check("valido_cnt_b", 48'(valido_cnt), 48'd2);

    // Stuck-low busy line: timeout
    leer = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) leer = 1'b0;
    end while (ocupado === 1'b1 && n < 400);
    check("to_cycles", 48'(n), 48'd259);
    check("to_flag", 48'(error_to), 48'h1);
    check("to_lea", 48'(lea), 48'h0);
    check_snap("to_snap_kept", SNAP_B);
    @(negedge clk);
    check("to_flag_sticky", 48'(error_to), 48'h1);
    check("valido_cnt_to", 48'(valido_cnt), 48'd2);

    // Mid-read reset during WAIT of index 3
    start_read();
    check("to_flag_cleared", 48'(error_to), 48'h0);
    for (int i = 0; i < 3; i++) serve(ADDRS[47-8*i -: 8], SNAP_C[47-8*i -: 8]);
    wait_wait(8'h24);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("midreset_outs");
    check_snap("midreset_snap", 48'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("midreset_idle");

    // Read after the aborted one completes normally
    vc = valido_cnt;
    start_read();
    run_read(SNAP_C, 48'h0, "read_c");
    @(negedge clk);
    check("idle_c", 48'(ocupado), 48'h0);
    check("valido_cnt_c", 48'(valido_cnt - vc), 48'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
